// File: rtl/mc_run_if.sv
// Command/result bus between the host, the Monte Carlo datapath and mc_run_ctrl.
// The controller connects through the slave modport; the host/datapath side uses master.
interface mc_run_if #(
   parameter int CW = 32
);
   logic          start;
   logic          abort;
   logic [CW-1:0] n_trials;
   logic          seed_dv;
   logic [31:0]   seed_a;
   logic [31:0]   seed_b;
   logic          issue;
   logic          res_valid;
   logic          res_hit;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          err;
   logic [CW-1:0] hits;
   logic [CW-1:0] misses;

   modport master (
      output start, abort, n_trials, res_valid, res_hit,
      input  seed_dv, seed_a, seed_b, issue, busy, done, aborted, err, hits, misses
   );

   modport slave (
      input  start, abort, n_trials, res_valid, res_hit,
      output seed_dv, seed_a, seed_b, issue, busy, done, aborted, err, hits, misses
   );
endinterface

// File: rtl/mc_run_ctrl.sv
// Run controller for the Monte Carlo pi datapath: seeds the LFSRs, issues darts under a
// credit limit, tallies hit/miss results, and handles abort with an in-flight flush.
module mc_run_ctrl #(
   parameter int          CW       = 32,
   parameter logic [31:0] SEED_A   = 32'hDEADBEEF,
   parameter logic [31:0] SEED_B   = 32'h0F00BA20,
   parameter int          MAX_INFL = 4
) (
   input logic     clk,
   input logic     rst,
   mc_run_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SEED, ISSUE, DRAIN, FLUSH} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] n_lat, issued, returned, hits_q, misses_q, outstanding;
   logic [31:0]   run_idx;
   logic          done_q, aborted_q, err_q;
   logic          can_issue, counting, ret_ok, accept, drain_done, flush_done;

   assign outstanding = issued - returned;
   assign can_issue   = (state == ISSUE) && (issued < n_lat) && (outstanding < CW'(MAX_INFL));
   assign counting    = (state == SEED) || (state == ISSUE) || (state == DRAIN);
   // Any strobe with nothing outstanding (or while idle) is a protocol error, not a result.
   assign ret_ok      = bus.res_valid && (outstanding != '0) && (state != IDLE);
   assign accept      = bus.start && !bus.abort;
   assign drain_done  = (returned + CW'(ret_ok)) == n_lat;
   assign flush_done  = outstanding == CW'(ret_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept && bus.n_trials != '0) state_nxt = SEED;
         SEED:  state_nxt = bus.abort ? FLUSH : ISSUE;
         ISSUE: begin
            if (bus.abort)                                state_nxt = FLUSH;
            else if (can_issue && (issued + 1'b1 == n_lat)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.abort)      state_nxt = FLUSH;
            else if (drain_done) state_nxt = IDLE;
         end
         FLUSH: if (flush_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.seed_dv = (state == SEED);
      bus.seed_a  = (state == SEED) ? (SEED_A ^ run_idx) : '0;
      bus.seed_b  = (state == SEED) ? (SEED_B ^ run_idx) : '0;
      bus.issue   = can_issue;
      bus.busy    = (state != IDLE);
      bus.done    = done_q;
      bus.aborted = aborted_q;
      bus.err     = err_q;
      bus.hits    = hits_q;
      bus.misses  = misses_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_lat     <= '0;
         issued    <= '0;
         returned  <= '0;
         hits_q    <= '0;
         misses_q  <= '0;
         run_idx   <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (state == IDLE && accept) begin
            n_lat     <= bus.n_trials;
            issued    <= '0;
            returned  <= '0;
            hits_q    <= '0;
            misses_q  <= '0;
            done_q    <= (bus.n_trials == '0);
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
         end
         if (can_issue) issued <= issued + 1'b1;
         // Results landing in FLUSH only release credit; the tallies stay frozen.
         if (ret_ok) begin
            returned <= returned + 1'b1;
            if (counting) begin
               if (bus.res_hit) hits_q   <= hits_q + 1'b1;
               else             misses_q <= misses_q + 1'b1;
            end
         end
         if (bus.res_valid && !ret_ok) err_q <= 1'b1;
         if (state == DRAIN && !bus.abort && drain_done) begin
            done_q  <= 1'b1;
            run_idx <= run_idx + 1'b1;
         end
         if (state == FLUSH && flush_done) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mc_run_ctrl.sv
// Directed bench for mc_run_ctrl: a cycle table for short runs plus a latency-configurable
// datapath model for the credit-limit, abort, reset and back-to-back run sequences.
module tb_mc_run_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mc_run_if #(.CW(32)) bus ();

   mc_run_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Datapath model: fixed latency, hit pattern 1101101101 by dart number within a run.
   logic        dp_en = 1'b0, man_valid = 1'b0, man_hit = 1'b0;
   logic        mdl_valid = 1'b0, mdl_hit = 1'b0;
   logic [15:0] dv = '0, dh = '0;
   logic [9:0]  pat = 10'b1011011011;
   int          lat = 2, dart_no = 0, seed_cnt = 0, issue_cnt = 0, viol = 0, mon_out = 0;

   assign bus.res_valid = dp_en ? mdl_valid : man_valid;
   assign bus.res_hit   = dp_en ? mdl_hit : man_hit;

   always @(negedge clk) begin
      if (rst) begin
         dv = '0; dh = '0; mdl_valid = 1'b0; mdl_hit = 1'b0; mon_out = 0;
      end else begin
         mdl_valid = dv[0];
         mdl_hit   = dh[0];
         dv = dv >> 1;
         dh = dh >> 1;
         if (bus.seed_dv) begin
            dart_no = 0; mon_out = 0; seed_cnt++;
         end
         if (bus.issue) begin
            if (mon_out >= 4) viol++;
            issue_cnt++;
            dv[lat-1] = 1'b1;
            dh[lat-1] = pat[dart_no % 10];
            dart_no++;
         end
         if (bus.issue) mon_out++;
         if (dp_en && mdl_valid && mon_out > 0) mon_out--;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_seed_dv"}, 32'(bus.seed_dv), 0);
      chk({tag, "_seed_a"},  bus.seed_a, 0);
      chk({tag, "_seed_b"},  bus.seed_b, 0);
      chk({tag, "_issue"},   32'(bus.issue), 0);
      chk({tag, "_busy"},    32'(bus.busy), 0);
      chk({tag, "_done"},    32'(bus.done), 0);
      chk({tag, "_aborted"}, 32'(bus.aborted), 0);
      chk({tag, "_err"},     32'(bus.err), 0);
      chk({tag, "_hits"},    bus.hits, 0);
      chk({tag, "_misses"},  bus.misses, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      #1 chk_zero(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Start a run and check the start -> seed_dv (t+1) -> first issue (t+2) latency.
   task automatic run(input int n, input logic [31:0] sa, input logic [31:0] sb);
      @(negedge clk);
      bus.start = 1'b1; bus.n_trials = n;
      #1 chk("start_busy", 32'(bus.busy), 0);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("seed_dv", 32'(bus.seed_dv), 1);
      chk("seed_a", bus.seed_a, sa);
      chk("seed_b", bus.seed_b, sb);
      @(negedge clk);
      #1 chk("first_issue", 32'(bus.issue), 1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (bus.busy && k < 2000) begin
         @(negedge clk); #1; k++;
      end
      chk({tag, "_timeout"}, 32'(k < 2000), 1);
   endtask

   typedef struct {
      logic        start, abort;
      logic [31:0] n;
      logic        rv, rh;
      logic        seed_dv, issue, busy, done, err;
      logic [31:0] hits, misses;
   } vec_t;

   vec_t tv[12];

   initial begin
      int base, cnt, k, fb, sc, ic;
      // start abort n rv rh | seed_dv issue busy done err hits misses
      tv[0]  = '{1, 0, 2, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      tv[1]  = '{0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0};
      tv[2]  = '{0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0};
      tv[3]  = '{0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0, 0};
      tv[4]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1, 0};
      tv[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1};
      tv[6]  = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 1};
      tv[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0};
      tv[8]  = '{0, 0, 0, 1, 1,  0, 0, 0, 1, 0, 0, 0};
      tv[9]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0};
      tv[10] = '{1, 1, 5, 0, 0,  0, 0, 0, 1, 1, 0, 0};
      tv[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0};

      bus.start = 1'b0; bus.abort = 1'b0; bus.n_trials = '0;
      do_reset("rst0");

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.start = tv[i].start; bus.abort = tv[i].abort; bus.n_trials = tv[i].n;
         man_valid = tv[i].rv; man_hit = tv[i].rh;
         #1;
         chk($sformatf("v%0d_seed_dv", i), 32'(bus.seed_dv), 32'(tv[i].seed_dv));
         chk($sformatf("v%0d_issue", i),   32'(bus.issue),   32'(tv[i].issue));
         chk($sformatf("v%0d_busy", i),    32'(bus.busy),    32'(tv[i].busy));
         chk($sformatf("v%0d_done", i),    32'(bus.done),    32'(tv[i].done));
         chk($sformatf("v%0d_err", i),     32'(bus.err),     32'(tv[i].err));
         chk($sformatf("v%0d_hits", i),    bus.hits,         tv[i].hits);
         chk($sformatf("v%0d_misses", i),  bus.misses,       tv[i].misses);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0; man_valid = 1'b0; man_hit = 1'b0;

      // Basic run, latency 2
      do_reset("rst1");
      dp_en = 1'b1; lat = 2;
      ic = issue_cnt;
      run(10, 32'hDEADBEEF, 32'h0F00BA20);
      wait_idle("t1");
      chk("t1_hits", bus.hits, 7);
      chk("t1_misses", bus.misses, 3);
      chk("t1_done", 32'(bus.done), 1);
      chk("t1_err", 32'(bus.err), 0);
      chk("t1_issues", 32'(issue_cnt - ic), 10);

      // Credit limit, latency 8
      lat = 8; viol = 0; ic = issue_cnt;
      run(20, 32'hDEADBEEE, 32'h0F00BA21);
      wait_idle("t2");
      chk("t2_credit_viol", 32'(viol), 0);
      chk("t2_issues", 32'(issue_cnt - ic), 20);
      chk("t2_hits", bus.hits, 14);
      chk("t2_misses", bus.misses, 6);
      chk("t2_done", 32'(bus.done), 1);

      // n == 0
      sc = seed_cnt; ic = issue_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.n_trials = 0;
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("t3_done", 32'(bus.done), 1);
      chk("t3_busy", 32'(bus.busy), 0);
      chk("t3_hits", bus.hits, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("t3_seeds", 32'(seed_cnt - sc), 0);
      chk("t3_issues", 32'(issue_cnt - ic), 0);

      // Abort in the cycle of the 40th issue; 3 darts remain in flight
      lat = 3;
      run(100, 32'hDEADBEED, 32'h0F00BA22);
      cnt = 1; k = 0;
      while (cnt < 40 && k < 500) begin
         @(negedge clk); #1; k++;
         if (bus.issue) cnt++;
      end
      chk("t4_reach40", 32'(cnt), 40);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      #1;
      base = issue_cnt;
      chk("t4_no_issue", 32'(bus.issue), 0);
      fb = 0;
      while (bus.busy && fb < 50) begin
         fb++; @(negedge clk); #1;
      end
      chk("t4_flush_cycles", 32'(fb), 3);
      chk("t4_late_issue", 32'(issue_cnt - base), 0);
      chk("t4_hits", bus.hits, 26);
      chk("t4_misses", bus.misses, 11);
      chk("t4_aborted", 32'(bus.aborted), 1);
      chk("t4_done", 32'(bus.done), 0);
      chk("t4_err", 32'(bus.err), 0);

      // Spurious strobe in IDLE, then async reset mid-ISSUE
      dp_en = 1'b0;
      @(negedge clk);
      man_valid = 1'b1; man_hit = 1'b1;
      @(negedge clk);
      man_valid = 1'b0; man_hit = 1'b0;
      #1;
      chk("t6_err", 32'(bus.err), 1);
      chk("t6_hits", bus.hits, 26);
      chk("t6_misses", bus.misses, 11);
      dp_en = 1'b1; lat = 2;
      run(10, 32'hDEADBEED, 32'h0F00BA22);
      chk("t6_err_cleared", 32'(bus.err), 0);
      repeat (3) @(negedge clk);
      #1 chk("t6_busy_mid", 32'(bus.busy), 1);
      #2 rst = 1'b1;
      #1 chk_zero("t6_async");
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back runs; start while busy and start+abort in IDLE are ignored
      sc = seed_cnt;
      run(5, 32'hDEADBEEF, 32'h0F00BA20);
      @(negedge clk);
      bus.start = 1'b1; bus.n_trials = 7;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle("t5a");
      chk("t5a_hits", bus.hits, 4);
      chk("t5a_misses", bus.misses, 1);
      chk("t5a_seeds", 32'(seed_cnt - sc), 1);
      run(5, 32'hDEADBEEE, 32'h0F00BA21);
      wait_idle("t5b");
      chk("t5b_hits", bus.hits, 4);
      chk("t5b_done", 32'(bus.done), 1);
      sc = seed_cnt;
      @(negedge clk);
      bus.start = 1'b1; bus.abort = 1'b1; bus.n_trials = 5;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      #1;
      chk("t5_sa_busy", 32'(bus.busy), 0);
      chk("t5_sa_done", 32'(bus.done), 1);
      repeat (2) @(negedge clk);
      #1 chk("t5_sa_seeds", 32'(seed_cnt - sc), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
